writeback_block_buffer: RTL and testbench



---
 rtl/stereo_pkg.sv | 17 +
 rtl/block_addr_gen.sv | 34 +++
 rtl/writeback_block_buffer.sv | 177 +++++++++++++++++
 tb/tb_writeback_block_buffer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/stereo_pkg.sv
// stereo_pkg: shared sizes, port widths, frame geometry and writeback FSM states
package stereo_pkg;
    localparam int WORD_W        = 48;
    localparam int BLOCK_SIZE    = 6;
    localparam int WORDS_PER_ROW = 40;
    localparam int ROWS          = 320;
    localparam int READ_LAT      = 2;
    localparam int FRAME_WORDS   = ROWS * WORDS_PER_ROW;
    localparam int X_W           = $clog2(WORDS_PER_ROW) + 1;
    localparam int Y_W           = $clog2(ROWS) + 1;
    localparam int YS_W          = $clog2(ROWS) + 2;
    localparam int ADDR_W        = $clog2(2 * FRAME_WORDS);
    localparam int ROW_W         = $clog2(BLOCK_SIZE);
    localparam int CNT_W         = $clog2(BLOCK_SIZE + READ_LAT) + 1;

    typedef enum logic [1:0] {IDLE, WRITE, VERIFY, FINISH} wb_state_e;
endpackage

// File: rtl/block_addr_gen.sv
// block_addr_gen: registered (frame, y, row, x) -> frame BRAM word address
//   clk_in, rst_n_in : clock, synchronous active-low reset (address clears to 0)
//   en_in            : load a new address this edge, otherwise hold
//   frame_in, y_in, row_in, x_in : block origin and row offset
//   addr_out         : frame*FRAME_WORDS + (y+row)*WORDS_PER_ROW + x, one cycle later
import stereo_pkg::*;

module block_addr_gen (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              en_in,
    input  logic              frame_in,
    input  logic [Y_W-1:0]    y_in,
    input  logic [ROW_W-1:0]  row_in,
    input  logic [X_W-1:0]    x_in,
    output logic [ADDR_W-1:0] addr_out
);
    logic [ADDR_W-1:0] addr_d, addr_q;

    always_comb begin
        addr_d = addr_q;
        if (en_in)
            addr_d = (frame_in ? ADDR_W'(FRAME_WORDS) : '0)
                   + (ADDR_W'(y_in) + ADDR_W'(row_in)) * ADDR_W'(WORDS_PER_ROW)
                   + ADDR_W'(x_in);
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) addr_q <= '0;
        else           addr_q <= addr_d;
    end

    assign addr_out = addr_q;
endmodule

// File: rtl/writeback_block_buffer.sv
// writeback_block_buffer: accepts one BLOCK_SIZE-row block and writes it row by row into the dual-frame BRAM
//   clk_in, rst_n_in     : clock, synchronous active-low reset
//   valid_in, ready_out  : block handshake (ready only in IDLE and out of reset)
//   x_word_in, y_in, frame_sel_in, block_in : block origin, frame and row words (index 0 = top row)
//   addr_out, din_out, we_out, dout_in      : BRAM port (dout_in used only by readback verify)
//   done_out, error_out  : end-of-block pulse; error marks an out-of-range reject
//   mismatch_out         : readback compare failed, held until next accept
// Optional macro WRITEBACK_READBACK_VERIFY_EN adds a VERIFY pass that reads the block back.
import stereo_pkg::*;

module writeback_block_buffer (
    input  logic                                clk_in,
    input  logic                                rst_n_in,
    input  logic                                valid_in,
    output logic                                ready_out,
    input  logic [X_W-1:0]                      x_word_in,
    input  logic [Y_W-1:0]                      y_in,
    input  logic                                frame_sel_in,
    input  logic [BLOCK_SIZE-1:0][WORD_W-1:0]   block_in,
    output logic [ADDR_W-1:0]                   addr_out,
    output logic [WORD_W-1:0]                   din_out,
    output logic                                we_out,
    input  logic [WORD_W-1:0]                   dout_in,
    output logic                                done_out,
    output logic                                error_out,
    output logic                                mismatch_out
);
    wb_state_e                       state_d, state_q;
    logic [CNT_W-1:0]                cnt_d, cnt_q;
    logic [BLOCK_SIZE-1:0][WORD_W-1:0] blk_d, blk_q;
    logic                            frame_d, frame_q;
    logic [X_W-1:0]                  x_d, x_q;
    logic [Y_W-1:0]                  y_d, y_q;
    logic [WORD_W-1:0]               din_d, din_q;
    logic                            we_d, we_q, done_d, done_q, err_d, err_q, mism_d, mism_q;
    logic                            ag_en, ag_frame, accept, in_range;
    logic [Y_W-1:0]                  ag_y;
    logic [X_W-1:0]                  ag_x;
    logic [ROW_W-1:0]                ag_row, nxt_row;

    assign ready_out = (state_q == IDLE) && rst_n_in;
    assign accept    = valid_in && ready_out;
    assign in_range  = (x_word_in < X_W'(WORDS_PER_ROW))
                    && (YS_W'(y_in) + YS_W'(BLOCK_SIZE) <= YS_W'(ROWS));
    assign nxt_row   = ROW_W'(cnt_q + 1'b1);

    // The address generator is registered, so each edge is fed the row that
    // must appear on the BRAM port in the following cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        blk_d    = blk_q;
        frame_d  = frame_q;
        x_d      = x_q;
        y_d      = y_q;
        din_d    = din_q;
        we_d     = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        mism_d   = mism_q;
        ag_en    = 1'b0;
        ag_frame = frame_q;
        ag_y     = y_q;
        ag_x     = x_q;
        ag_row   = nxt_row;
        case (state_q)
            IDLE: if (accept) begin
                blk_d   = block_in;
                frame_d = frame_sel_in;
                x_d     = x_word_in;
                y_d     = y_in;
                cnt_d   = '0;
                mism_d  = 1'b0;
                if (in_range) begin
                    state_d  = WRITE;
                    we_d     = 1'b1;
                    din_d    = block_in[0];
                    ag_en    = 1'b1;
                    ag_frame = frame_sel_in;
                    ag_y     = y_in;
                    ag_x     = x_word_in;
                    ag_row   = '0;
                end else begin
                    state_d = FINISH;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end
            end
            WRITE: if (cnt_q == CNT_W'(BLOCK_SIZE - 1)) begin
`ifdef WRITEBACK_READBACK_VERIFY_EN
                state_d = VERIFY;
                cnt_d   = '0;
                ag_en   = 1'b1;
                ag_row  = '0;
                din_d   = blk_q[0];
`else
                state_d = FINISH;
                done_d  = 1'b1;
`endif
            end else begin
                cnt_d = cnt_q + 1'b1;
                we_d  = 1'b1;
                din_d = blk_q[nxt_row];
                ag_en = 1'b1;
            end
`ifdef WRITEBACK_READBACK_VERIFY_EN
            // Read addresses go out while cnt < BLOCK_SIZE; each returns READ_LAT cycles later.
            VERIFY: begin
                if (cnt_q < CNT_W'(BLOCK_SIZE - 1)) begin
                    ag_en = 1'b1;
                    din_d = blk_q[nxt_row];
                end
                if (cnt_q >= CNT_W'(READ_LAT)
                    && dout_in != blk_q[ROW_W'(cnt_q - CNT_W'(READ_LAT))])
                    mism_d = 1'b1;
                if (cnt_q == CNT_W'(BLOCK_SIZE + READ_LAT - 1)) begin
                    state_d = FINISH;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            din_q   <= '0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            mism_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            din_q   <= din_d;
            we_q    <= we_d;
            done_q  <= done_d;
            err_q   <= err_d;
            mism_q  <= mism_d;
        end
    end

    always_ff @(posedge clk_in) begin
        blk_q   <= blk_d;
        frame_q <= frame_d;
        x_q     <= x_d;
        y_q     <= y_d;
    end

    block_addr_gen u_addr (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .en_in    (ag_en),
        .frame_in (ag_frame),
        .y_in     (ag_y),
        .row_in   (ag_row),
        .x_in     (ag_x),
        .addr_out (addr_out)
    );

    assign din_out   = din_q;
    assign we_out    = we_q;
    assign done_out  = done_q;
    assign error_out = err_q;
`ifdef WRITEBACK_READBACK_VERIFY_EN
    assign mismatch_out = mism_q;
`else
    logic unused_dout;
    assign unused_dout  = ^dout_in;
    assign mismatch_out = 1'b0;
`endif
endmodule

// File: tb/tb_writeback_block_buffer.sv
// tb_writeback_block_buffer: directed scoreboard bench for writeback_block_buffer with a BRAM model
import stereo_pkg::*;

module tb_writeback_block_buffer;
    logic                              clk_in = 1'b0;
    logic                              rst_n_in, valid_in, ready_out, frame_sel_in;
    logic [X_W-1:0]                    x_word_in;
    logic [Y_W-1:0]                    y_in;
    logic [BLOCK_SIZE-1:0][WORD_W-1:0] block_in;
    logic [ADDR_W-1:0]                 addr_out;
    logic [WORD_W-1:0]                 din_out, dout_in, rd1;
    logic                              we_out, done_out, error_out, mismatch_out;

`ifdef WRITEBACK_READBACK_VERIFY_EN
    localparam int DL = BLOCK_SIZE + 1 + BLOCK_SIZE + READ_LAT;
`else
    localparam int DL = BLOCK_SIZE + 1;
`endif

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [WORD_W-1:0] d;
    } wr_t;

    wr_t               q[$];
    logic [WORD_W-1:0] mem [2*FRAME_WORDS];
    bit                corrupt = 1'b0;
    logic [ADDR_W-1:0] bad_addr = '0;
    int                errors = 0;
    int                checks = 0;

    always #5 clk_in = ~clk_in;

    writeback_block_buffer dut (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .valid_in     (valid_in),
        .ready_out    (ready_out),
        .x_word_in    (x_word_in),
        .y_in         (y_in),
        .frame_sel_in (frame_sel_in),
        .block_in     (block_in),
        .addr_out     (addr_out),
        .din_out      (din_out),
        .we_out       (we_out),
        .dout_in      (dout_in),
        .done_out     (done_out),
        .error_out    (error_out),
        .mismatch_out (mismatch_out)
    );

    always @(posedge clk_in) begin
        if (we_out) mem[addr_out] <= din_out;
        rd1     <= mem[addr_out] ^ WORD_W'(corrupt && addr_out == bad_addr);
        dout_in <= rd1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk_in) begin
        if (we_out) begin
            if (q.size() == 0) chk("unexpected_we", {48'd0, addr_out}, 64'hFFFF);
            else begin
                wr_t e;
                e = q.pop_front();
                chk("wr_addr", 64'(addr_out), 64'(e.a));
                chk("wr_data", 64'(din_out), 64'(e.d));
            end
        end
    end

    task automatic drive(input logic f, input int x, input int y, input logic [WORD_W-1:0] base);
        frame_sel_in = f;
        x_word_in    = X_W'(x);
        y_in         = Y_W'(y);
        for (int r = 0; r < BLOCK_SIZE; r++) block_in[r] = base + WORD_W'(r);
    endtask

    task automatic push_rows(input logic f, input int x, input int y, input logic [WORD_W-1:0] base, input int n);
        for (int r = 0; r < n; r++)
            q.push_back('{ADDR_W'(int'(f) * ROWS * WORDS_PER_ROW + (y + r) * WORDS_PER_ROW + x),
                          base + WORD_W'(r)});
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!ready_out && n < 100) begin
            @(negedge clk_in);
            n++;
        end
        chk("ready_wait", ready_out, 1);
    endtask

    task automatic run_block(input logic f, input int x, input int y, input logic [WORD_W-1:0] base,
                             input bit ok, input bit exp_mm);
        int n;
        wait_ready();
        drive(f, x, y, base);
        valid_in = 1'b1;
        if (ok) push_rows(f, x, y, base, BLOCK_SIZE);
        @(negedge clk_in);
        valid_in = 1'b0;
        drive(~f, 0, 0, 48'h5A5A);
        chk("we_first", we_out, ok);
        chk("mm_clear", mismatch_out, 0);
        n = 1;
        while (!done_out && n < 60) begin
            @(negedge clk_in);
            n++;
        end
        chk("done_lat", n, ok ? DL : 1);
        chk("error", error_out, !ok);
        chk("mismatch", mismatch_out, exp_mm);
        @(negedge clk_in);
        chk("ready_after", ready_out, 1);
        chk("done_pulse", done_out, 0);
        chk("sb_empty", q.size(), 0);
    endtask

    initial begin
        int n, rdy_at, wes, dones;
        rst_n_in = 1'b0;
        valid_in = 1'b0;
        drive(0, 0, 0, '0);
        repeat (2) @(negedge clk_in);
        chk("rst_ready", ready_out, 0);
        chk("rst_we", we_out, 0);
        chk("rst_addr", addr_out, 0);
        chk("rst_din", din_out, 0);
        chk("rst_done", done_out, 0);
        chk("rst_err", error_out, 0);
        chk("rst_mm", mismatch_out, 0);
        rst_n_in = 1'b1;
        @(negedge clk_in);
        chk("ready_post_rst", ready_out, 1);

        run_block(0, 3, 10, 48'hA0, 1, 0);
        chk("t1_addr0", mem[403], 48'hA0);
        chk("t1_addr5", mem[603], 48'hA5);
        run_block(1, 0, 0, 48'hB0, 1, 0);
        for (int r = 0; r < BLOCK_SIZE; r++) chk("t2_bram", mem[12800 + 40 * r], 48'hB0 + WORD_W'(r));
        run_block(1, 39, 314, 48'h1234_0000, 1, 0);
        chk("t2b_last", mem[25599], 48'h1234_0005);
        run_block(0, 0, 315, 48'hEE, 0, 0);
        run_block(1, 40, 0, 48'hEF, 0, 0);

        wait_ready();
        drive(0, 1, 100, 48'h100);
        push_rows(0, 1, 100, 48'h100, BLOCK_SIZE);
        valid_in = 1'b1;
        @(negedge clk_in);
        drive(1, 2, 200, 48'h200);
        push_rows(1, 2, 200, 48'h200, BLOCK_SIZE);
        rdy_at = 0; wes = 0; dones = 0;
        for (n = 1; n <= 2 * DL + 1; n++) begin
            wes   += int'(we_out);
            dones += int'(done_out);
            if (rdy_at != 0 && n == rdy_at + 1) valid_in = 1'b0;
            if (ready_out && valid_in && rdy_at == 0) rdy_at = n;
            @(negedge clk_in);
        end
        valid_in = 1'b0;
        chk("b2b_accept", rdy_at, DL + 1);
        chk("b2b_writes", wes, 2 * BLOCK_SIZE);
        chk("b2b_dones", dones, 2);
        chk("b2b_ready", ready_out, 1);
        chk("b2b_sb", q.size(), 0);

        wait_ready();
        drive(0, 5, 50, 48'hC0);
        push_rows(0, 5, 50, 48'hC0, 3);
        valid_in = 1'b1;
        @(negedge clk_in);
        valid_in = 1'b0;
        repeat (2) @(negedge clk_in);
        rst_n_in = 1'b0;
        @(negedge clk_in);
        chk("mid_rst_we", we_out, 0);
        chk("mid_rst_ready", ready_out, 0);
        @(negedge clk_in);
        chk("mid_rst_done", done_out, 0);
        rst_n_in = 1'b1;
        @(negedge clk_in);
        chk("mid_rst_ready_back", ready_out, 1);
        chk("mid_rst_no_done", done_out, 0);
        chk("mid_rst_no_err", error_out, 0);
        chk("mid_rst_sb", q.size(), 0);
        for (int r = 0; r < 3; r++) chk("mid_rst_bram", mem[5 + (50 + r) * 40], 48'hC0 + WORD_W'(r));

`ifdef WRITEBACK_READBACK_VERIFY_EN
        corrupt  = 1'b1;
        bad_addr = ADDR_W'((20 + 4) * 40 + 7);
        run_block(0, 7, 20, 48'hD0, 1, 1);
        corrupt = 1'b0;
        run_block(0, 7, 20, 48'hE0, 1, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
